// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter unit of the MIPS CPU.
//   - pc_state_e : fetch state (RUN, SLOT, HALTED)
//   - DEFAULT_*  : default WIDTH, RESET_VECTOR, STEP and HALT_ADDR values
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int          DEFAULT_WIDTH        = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam int          DEFAULT_STEP         = 4;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  // RUN    : sequential fetch, redirect requests accepted
  // SLOT   : PCout is the delay-slot instruction, pending target held
  // HALTED : redirected to the halt address, only reset leaves
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SLOT   = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

endpackage : pc_pkg

// File: rtl/pc_adder.sv
// ---------------------------------------------------------------------------
// pc_adder
// WIDTH-bit incrementer: sum = a + STEP, wrapping modulo 2^WIDTH.
// Ports:
//   a   in  WIDTH  current program counter
//   sum out WIDTH  a + STEP
// ---------------------------------------------------------------------------
module pc_adder
  import pc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = DEFAULT_STEP
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Carry out of the top bit is dropped on purpose: the PC wraps.
  assign sum = a + STEP_W;

endmodule : pc_adder

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program-counter unit: owns the PC register, the sequential +STEP
// increment, a one-instruction branch delay slot and halt detection
// (a redirect to HALT_ADDR stops fetching until reset).
// Ports:
//   clk           in  1      clock, rising edge
//   reset         in  1      synchronous, active-low reset
//   clk_enable    in  1      advance enable; low holds all state
//   jump          in  1      unconditional redirect request
//   jump_target   in  WIDTH  jump destination
//   branch_taken  in  1      conditional branch resolved taken
//   branch_target in  WIDTH  branch destination
//   PCout         out WIDTH  current instruction address
//   PCplus4       out WIDTH  PCout + STEP (combinational)
//   delay_slot    out 1      PCout is a delay-slot instruction
//   active        out 1      unit is fetching (not halted)
//   redirect_err  out 1      one-cycle pulse: request rejected
// ---------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter int          WIDTH        = DEFAULT_WIDTH,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          STEP         = DEFAULT_STEP,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] PCout,
  output logic [WIDTH-1:0] PCplus4,
  output logic             delay_slot,
  output logic             active,
  output logic             redirect_err
);

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] HALT_PC  = WIDTH'(HALT_ADDR);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             delay_slot_q, delay_slot_d;
  logic             active_q, active_d;
  logic             redirect_err_q, redirect_err_d;

  logic [WIDTH-1:0] pc_plus_step;
  logic             req;
  logic [WIDTH-1:0] req_target;
  logic             req_misaligned;

  // Single incrementer shared by the PCplus4 output and the sequential next PC.
  pc_adder #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_pc_adder (
    .a   (pc_q),
    .sum (pc_plus_step)
  );

  // Jump has priority over a simultaneously taken branch.
  assign req        = jump | branch_taken;
  assign req_target = jump ? jump_target : branch_target;

  // A target that is not a multiple of STEP cannot be an instruction address.
  assign req_misaligned = ((req_target % STEP_W) != '0);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    tgt_d          = tgt_q;
    delay_slot_d   = delay_slot_q;
    active_d       = active_q;
    redirect_err_d = 1'b0;

    if (clk_enable) begin
      unique case (state_q)
        RUN: begin
          pc_d = pc_plus_step;
          if (req) begin
            if (req_misaligned) begin
              redirect_err_d = 1'b1;
            end else begin
              tgt_d   = req_target;
              state_d = SLOT;
            end
          end
        end

        SLOT: begin
          pc_d = tgt_q;
          // A redirect from inside the delay slot is not supported.
          redirect_err_d = req;
          state_d        = (tgt_q == HALT_PC) ? HALTED : RUN;
        end

        HALTED: begin
          pc_d = pc_q;
        end

        default: begin
          state_d = RUN;
        end
      endcase

      delay_slot_d = (state_d == SLOT);
      active_d     = (state_d != HALTED);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      tgt_q          <= '0;
      delay_slot_q   <= 1'b0;
      active_q       <= 1'b1;
      redirect_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      tgt_q          <= tgt_d;
      delay_slot_q   <= delay_slot_d;
      active_q       <= active_d;
      redirect_err_q <= redirect_err_d;
    end
  end

  assign PCout        = pc_q;
  assign PCplus4      = pc_plus_step;
  assign delay_slot   = delay_slot_q;
  assign active       = active_q;
  assign redirect_err = redirect_err_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, clk_enable, jump, branch_taken;
  logic [31:0] jump_target, branch_target;
  logic [31:0] pc_out, pc_plus4;
  logic        delay_slot, active, redirect_err;

  logic        reset8, clk_enable8, jump8, branch_taken8;
  logic [7:0]  jump_target8, branch_target8;
  logic [7:0]  pc_out8, pc_plus4_8;
  logic        delay_slot8, active8, redirect_err8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .PCout         (pc_out),
    .PCplus4       (pc_plus4),
    .delay_slot    (delay_slot),
    .active        (active),
    .redirect_err  (redirect_err)
  );

  pc_unit #(
    .WIDTH        (8),
    .RESET_VECTOR (32'h0000_00F8)
  ) dut8 (
    .clk           (clk),
    .reset         (reset8),
    .clk_enable    (clk_enable8),
    .jump          (jump8),
    .jump_target   (jump_target8),
    .branch_taken  (branch_taken8),
    .branch_target (branch_target8),
    .PCout         (pc_out8),
    .PCplus4       (pc_plus4_8),
    .delay_slot    (delay_slot8),
    .active        (active8),
    .redirect_err  (redirect_err8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_enable = 1'b0;
    tick(); tick();
    checks++; if (pc_out !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc: got %h want BFC00000", pc_out); end
    checks++; if (pc_plus4 !== 32'hBFC00004) begin errors++; $display("FAIL reset_pcplus4: got %h want BFC00004", pc_plus4); end
    checks++; if (delay_slot !== 1'b0) begin errors++; $display("FAIL reset_slot: got %b want 0", delay_slot); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL reset_active: got %b want 1", active); end
    checks++; if (redirect_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", redirect_err); end
    reset = 1'b1; clk_enable = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc_out !== 32'hBFC00000 + 32'(4*i)) begin errors++; $display("FAIL run_pc%0d: got %h want %h", i, pc_out, 32'hBFC00000 + 32'(4*i)); end
      checks++; if (delay_slot !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL run_flags%0d: got slot=%b active=%b want 0/1", i, delay_slot, active); end
    end
  endtask

  // Starts at PCout=BFC00010.
  task automatic test_branch_stall();
    branch_taken = 1'b1; branch_target = 32'hBFC00100;
    tick();
    branch_taken = 1'b0; branch_target = 32'h0;
    checks++; if (pc_out !== 32'hBFC00014 || delay_slot !== 1'b1) begin errors++; $display("FAIL br_slot: got pc=%h slot=%b want BFC00014/1", pc_out, delay_slot); end
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_out !== 32'hBFC00014 || delay_slot !== 1'b1) begin errors++; $display("FAIL br_stall%0d: got pc=%h slot=%b want BFC00014/1", i, pc_out, delay_slot); end
    end
    clk_enable = 1'b1;
    tick();
    checks++; if (pc_out !== 32'hBFC00100 || delay_slot !== 1'b0) begin errors++; $display("FAIL br_target: got pc=%h slot=%b want BFC00100/0", pc_out, delay_slot); end
    tick();
    checks++; if (pc_out !== 32'hBFC00104) begin errors++; $display("FAIL br_after: got %h want BFC00104", pc_out); end
  endtask

  // Starts at PCout=BFC00104.
  task automatic test_back_to_back();
    jump = 1'b1; jump_target = 32'hBFC00200;
    branch_taken = 1'b1; branch_target = 32'hBFC00300;
    tick();
    checks++; if (pc_out !== 32'hBFC00108 || delay_slot !== 1'b1) begin errors++; $display("FAIL both_slot: got pc=%h slot=%b want BFC00108/1", pc_out, delay_slot); end
    branch_taken = 1'b0; jump_target = 32'hBFC00400;
    tick();
    jump = 1'b0;
    checks++; if (pc_out !== 32'hBFC00200) begin errors++; $display("FAIL both_target: got %h want BFC00200", pc_out); end
    checks++; if (redirect_err !== 1'b1) begin errors++; $display("FAIL slot_req_err: got %b want 1", redirect_err); end
    tick();
    checks++; if (pc_out !== 32'hBFC00204 || redirect_err !== 1'b0) begin errors++; $display("FAIL slot_req_after: got pc=%h err=%b want BFC00204/0", pc_out, redirect_err); end
  endtask

  // Starts at PCout=BFC00204.
  task automatic test_misaligned();
    jump = 1'b1; jump_target = 32'hBFC00102;
    tick();
    checks++; if (pc_out !== 32'hBFC00208 || redirect_err !== 1'b1 || delay_slot !== 1'b0) begin errors++; $display("FAIL mis_jump: got pc=%h err=%b slot=%b want BFC00208/1/0", pc_out, redirect_err, delay_slot); end
    tick();
    jump = 1'b0;
    checks++; if (pc_out !== 32'hBFC0020C || redirect_err !== 1'b1) begin errors++; $display("FAIL mis_jump2: got pc=%h err=%b want BFC0020C/1", pc_out, redirect_err); end
    clk_enable = 1'b0;
    tick();
    checks++; if (pc_out !== 32'hBFC0020C || redirect_err !== 1'b0) begin errors++; $display("FAIL mis_stall: got pc=%h err=%b want BFC0020C/0", pc_out, redirect_err); end
    clk_enable = 1'b1;
    branch_taken = 1'b1; branch_target = 32'hBFC00101;
    tick();
    branch_taken = 1'b0;
    checks++; if (pc_out !== 32'hBFC00210 || redirect_err !== 1'b1) begin errors++; $display("FAIL mis_branch: got pc=%h err=%b want BFC00210/1", pc_out, redirect_err); end
    tick();
    checks++; if (pc_out !== 32'hBFC00214 || redirect_err !== 1'b0) begin errors++; $display("FAIL mis_after: got pc=%h err=%b want BFC00214/0", pc_out, redirect_err); end
  endtask

  task automatic test_halt();
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (pc_out !== 32'hBFC00020) begin errors++; $display("FAIL halt_pre: got %h want BFC00020", pc_out); end
    jump = 1'b1; jump_target = 32'h0;
    tick();
    jump = 1'b0;
    checks++; if (pc_out !== 32'hBFC00024 || delay_slot !== 1'b1) begin errors++; $display("FAIL halt_slot: got pc=%h slot=%b want BFC00024/1", pc_out, delay_slot); end
    tick();
    checks++; if (pc_out !== 32'h0 || active !== 1'b0 || delay_slot !== 1'b0) begin errors++; $display("FAIL halt_enter: got pc=%h active=%b slot=%b want 0/0/0", pc_out, active, delay_slot); end
    jump = 1'b1; jump_target = 32'hBFC00100;
    branch_taken = 1'b1; branch_target = 32'hBFC00300;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (pc_out !== 32'h0 || active !== 1'b0 || redirect_err !== 1'b0) begin errors++; $display("FAIL halt_hold%0d: got pc=%h active=%b err=%b want 0/0/0", i, pc_out, active, redirect_err); end
    end
    jump = 1'b0; branch_taken = 1'b0;
    reset = 1'b0;
    tick();
    checks++; if (pc_out !== 32'hBFC00000 || active !== 1'b1) begin errors++; $display("FAIL halt_exit: got pc=%h active=%b want BFC00000/1", pc_out, active); end
  endtask

  // Entered with reset asserted and PCout=BFC00000.
  task automatic test_reset_in_slot();
    reset = 1'b1;
    jump = 1'b1; jump_target = 32'hBFC00300;
    tick();
    jump = 1'b0;
    checks++; if (pc_out !== 32'hBFC00004 || delay_slot !== 1'b1) begin errors++; $display("FAIL rslot_slot: got pc=%h slot=%b want BFC00004/1", pc_out, delay_slot); end
    reset = 1'b0;
    tick();
    checks++; if (pc_out !== 32'hBFC00000 || delay_slot !== 1'b0) begin errors++; $display("FAIL rslot_reset: got pc=%h slot=%b want BFC00000/0", pc_out, delay_slot); end
    reset = 1'b1;
    tick();
    checks++; if (pc_out !== 32'hBFC00004 || delay_slot !== 1'b0) begin errors++; $display("FAIL rslot_discard: got pc=%h slot=%b want BFC00004/0", pc_out, delay_slot); end
  endtask

  task automatic test_wrap();
    reset8 = 1'b0; clk_enable8 = 1'b1;
    tick();
    reset8 = 1'b1;
    checks++; if (pc_out8 !== 8'hF8 || pc_plus4_8 !== 8'hFC) begin errors++; $display("FAIL wrap_reset: got pc=%h p4=%h want F8/FC", pc_out8, pc_plus4_8); end
    tick();
    checks++; if (pc_out8 !== 8'hFC || pc_plus4_8 !== 8'h00) begin errors++; $display("FAIL wrap_fc: got pc=%h p4=%h want FC/00", pc_out8, pc_plus4_8); end
    tick();
    checks++; if (pc_out8 !== 8'h00 || active8 !== 1'b1) begin errors++; $display("FAIL wrap_zero: got pc=%h active=%b want 00/1", pc_out8, active8); end
    tick();
    checks++; if (pc_out8 !== 8'h04 || active8 !== 1'b1) begin errors++; $display("FAIL wrap_04: got pc=%h active=%b want 04/1", pc_out8, active8); end
  endtask

  initial begin
    reset = 1'b0; clk_enable = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = 32'h0; branch_target = 32'h0;
    reset8 = 1'b0; clk_enable8 = 1'b0; jump8 = 1'b0; branch_taken8 = 1'b0;
    jump_target8 = 8'h0; branch_target8 = 8'h0;

    test_reset();
    test_free_run();
    test_branch_stall();
    test_back_to_back();
    test_misaligned();
    test_halt();
    test_reset_in_slot();
    test_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_unit
